// File: rtl/serial_tx.sv
// rtl/serial_tx.sv - UART-style serial transmitter: start, DATA_W data bits LSB first, optional even parity, one stop bit
`timescale 1ns/1ps
module serial_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 0
) (
    input  logic              clk,
    input  logic              async_reset,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_serial,
    output logic              tx_busy,
    output logic              tx_done
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(DATA_W - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t            state_q, state_d;
    logic [BW-1:0]     baud_q, baud_d;
    logic [CW-1:0]     bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              parity_q, parity_d;
    logic              done_q, done_d;
    logic              baud_last;

    always_ff @(posedge clk or negedge async_reset) begin
        if (!async_reset) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            done_q   <= done_d;
        end
    end

    // With CLKS_PER_BIT=1 the baud counter stays at zero and every cycle is a bit boundary.
    always_comb begin
        state_d   = state_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        done_d    = 1'b0;
        baud_last = (baud_q == BAUD_LAST);
        baud_d    = baud_last ? '0 : baud_q + BW'(1);
        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (tx_valid) begin
                    shift_d  = tx_data;
                    parity_d = ^tx_data;
                    bit_d    = '0;
                    state_d  = START;
                end
            end
            START: begin
                if (baud_last) state_d = DATA;
            end
            DATA: begin
                if (baud_last) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + CW'(1);
                    end
                end
            end
            PARITY: begin
                if (baud_last) state_d = STOP;
            end
            STOP: begin
                if (baud_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_serial = 1'b1;
        tx_ready  = (state_q == IDLE);
        tx_busy   = (state_q != IDLE);
        tx_done   = done_q;
        case (state_q)
            START:   tx_serial = 1'b0;
            DATA:    tx_serial = shift_q[0];
            PARITY:  tx_serial = parity_q;
            default: tx_serial = 1'b1;
        endcase
    end

endmodule

// File: doc/serial_tx.md
Name: serial_tx

Overview:
- Parallel-in, serial-out UART-style transmitter: start bit, DATA_W data bits LSB first, optional even parity bit, one stop bit.
- A flip-flop-based producer hands a word over a valid/ready handshake; the block serialises it onto one line.
- It is the transmit end of the team's serial link and drives the line that the receive-side flip-flop/shift-register chain samples.

Parameters:
- DATA_W, 8, data bits per frame (>=1)
- CLKS_PER_BIT, 4, clock cycles each line bit is held (>=1)
- PARITY_EN, 0, 1 inserts an even-parity bit after the data bits; 0 means no parity bit

Ports:
- clk  input  1  rising-edge clock; the only clock
- async_reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- tx_data  input  DATA_W  word to send; sampled only at acceptance
- tx_valid  input  1  producer has a word
- tx_ready  output  1  block can accept a word (high only in IDLE)
- tx_serial  output  1  serial line; idle high
- tx_busy  output  1  high while a frame is in flight
- tx_done  output  1  one-cycle pulse when a frame completes

Behaviour:
- Reset (async_reset=0), effective immediately without a clock edge:
  - State goes to IDLE.
  - tx_serial=1, tx_ready=1, tx_busy=0, tx_done=0.
  - Shift register and counters are cleared.
- All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- States:
  - IDLE, START, DATA, PARITY (only when PARITY_EN=1), STOP.
  - A bit counter tracks DATA_W data bits.
  - A baud counter (width clog2(CLKS_PER_BIT), min 1) holds each bit for exactly CLKS_PER_BIT cycles.
- Acceptance:
  - Occurs at a rising edge with state IDLE and tx_valid=1.
  - tx_data is latched into the shift register, parity is computed from the latched word, and state goes to START.
  - From that edge: tx_serial=0, tx_busy=1, tx_ready=0.
- START:
  - Line is 0 for CLKS_PER_BIT cycles, then DATA.
- DATA:
  - Line carries shift-register bit 0 (LSB first).
  - The register shifts right every CLKS_PER_BIT cycles.
  - After DATA_W bits, go to PARITY (if PARITY_EN=1) or STOP.
- PARITY:
  - Line is the XOR of all latched data bits for CLKS_PER_BIT cycles, then STOP.
- STOP:
  - Line is 1 for CLKS_PER_BIT cycles.
  - On the edge ending STOP: state goes to IDLE, tx_busy=0, tx_ready=1, and tx_done=1 for exactly one cycle.
- Frame length: (DATA_W+2+PARITY_EN)*CLKS_PER_BIT cycles, measured from the acceptance edge to the edge returning to IDLE.
- Back-to-back:
  - If tx_valid is high in the IDLE cycle where tx_done=1, that word is accepted at the next edge.
  - Minimum inter-frame idle-high gap is therefore exactly 1 cycle.
  - A new start bit begins (frame length + 1) cycles after the previous acceptance edge.
- tx_valid while busy is ignored.
- tx_data changes after acceptance do not affect the frame in flight.
- tx_valid dropping mid-frame has no effect on the frame in flight.
- Reset asserted mid-frame:
  - The frame is aborted; the line returns high immediately.
  - No tx_done pulse is generated.
  - The first edge after release with tx_valid=1 starts a clean frame.
- CLKS_PER_BIT=1: each bit lasts one cycle. The baud counter is degenerate but the same state sequence holds.

Test Plan:
1. Hold async_reset=0 for 3 cycles with tx_valid=1 and tx_data=8'hFF -> tx_serial=1, tx_ready=1, tx_busy=0, tx_done=0 throughout; no frame starts until after release.
2. Defaults, send 8'hA5 at edge t0 -> line is 0 (start), then 1,0,1,0,0,1,0,1, then 1 (stop), each held 4 cycles; tx_busy=1 for t0..t0+40; tx_done=1 only in cycle t0+40..t0+41.
3. PARITY_EN=1, send 8'h07 -> line is 0, then 1,1,1,0,0,0,0,0, then parity 1, then stop 1; frame is 44 cycles; tx_done at t0+44.
4. Send 8'h3C, then at t0+8 change tx_data to 8'hFF and hold tx_valid=1 -> the first frame still carries 0,0,1,1,1,1,0,0; the second frame (8'hFF) is accepted at t0+41, so its start bit is low from t0+41.
5. Assert async_reset=0 between clock edges at t0+14 mid-DATA -> tx_serial=1 and tx_busy=0 before the next edge; no tx_done. Release, send 8'h5A -> a correct full 40-cycle frame follows.
6. CLKS_PER_BIT=1, send 8'h81 -> 10-cycle frame: 0,1,0,0,0,0,0,0,1,1; tx_done at t0+10.
